// File: rtl/memo_decoder.sv
// Receive side of the memo packer: rebuilds the source bus from its redundant
// copies, flags copies that disagree, and queues results toward a valid/ready consumer.
module memo_decoder #(
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_struct,
    input  logic [1:0][3:0]            in_matrix,
    input  logic signed [2:0]          in_unpacked0,
    input  logic signed [2:0]          in_unpacked1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_bus,
    output logic [7:0]                 out_lo_sext,
    output logic                       out_err,
    output logic [ERR_CNT_W-1:0]       err_count,
    output logic                       err_sticky,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [3:0]        parts_hi;
        logic signed [1:0] parts_lo;
    } memo_struct_t;

    typedef struct packed {
        logic [7:0] bus;
        logic [7:0] lo_sext;
        logic       err;
    } entry_t;

    memo_struct_t rec;
    entry_t       new_entry;
    entry_t       head;
    entry_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          rec_err;

    assign rec = memo_struct_t'(in_struct);

    assign rec_err = (in_matrix[0] != rec.parts_hi)
                   | (in_matrix[1][1:0] != rec.parts_lo)
                   | (in_unpacked0 != rec.parts_hi[2:0])
                   | (in_unpacked1[1:0] != rec.parts_lo)
                   | (in_unpacked1[2] != rec.parts_hi[0]);

    always_comb begin
        new_entry.bus     = {in_matrix[1][3:2], rec.parts_lo, rec.parts_hi};
        new_entry.lo_sext = {{6{rec.parts_lo[1]}}, rec.parts_lo};
        new_entry.err     = rec_err;
    end

    // Readiness depends only on occupancy so a full FIFO never accepts on a same-cycle pop.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push && rec_err) begin
                err_sticky <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    // Unwritten slots hold junk, so the head is masked whenever the FIFO is empty.
    assign head        = mem[rd_ptr];
    assign out_bus     = out_valid ? head.bus     : 8'h00;
    assign out_lo_sext = out_valid ? head.lo_sext : 8'h00;
    assign out_err     = out_valid ? head.err     : 1'b0;

endmodule

// File: tb/tb_memo_decoder.sv
// Bench for memo_decoder: a queue-based reference model checked every cycle against
// two instances (default and 2-bit error counter), plus directed literal checks.
module tb_memo_decoder;

    localparam int DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [5:0]        in_struct;
    logic [1:0][3:0]   in_matrix;
    logic signed [2:0] in_unpacked0;
    logic signed [2:0] in_unpacked1;
    logic              out_ready;

    logic       in_ready,    s_in_ready;
    logic       out_valid,   s_out_valid;
    logic [7:0] out_bus,     s_out_bus;
    logic [7:0] out_lo_sext, s_out_lo_sext;
    logic       out_err,     s_out_err;
    logic [7:0] err_count;
    logic [1:0] s_err_count;
    logic       err_sticky,  s_err_sticky;
    logic [2:0] count,       s_count;

    int checks = 0;
    int errors = 0;

    memo_decoder #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_struct(in_struct), .in_matrix(in_matrix),
        .in_unpacked0(in_unpacked0), .in_unpacked1(in_unpacked1),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
        .out_lo_sext(out_lo_sext), .out_err(out_err), .err_count(err_count),
        .err_sticky(err_sticky), .count(count)
    );

    memo_decoder #(.DEPTH(DEPTH), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_struct(in_struct), .in_matrix(in_matrix),
        .in_unpacked0(in_unpacked0), .in_unpacked1(in_unpacked1),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_bus(s_out_bus),
        .out_lo_sext(s_out_lo_sext), .out_err(s_out_err), .err_count(s_err_count),
        .err_sticky(s_err_sticky), .count(s_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {bus, lo_sext, err} entries in accept order.
    logic [16:0] mq[$];
    int          mErr8, mErr2;
    bit          mSticky;
    bit          modelReady = 0;
    int          mHi, mLo, mTop, mLoS;
    bit          mAcc, mPop, mBad;
    logic [16:0] mEntry;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mErr8   = 0;
            mErr2   = 0;
            mSticky = 0;
        end else begin
            mAcc = in_valid && (mq.size() < DEPTH);
            mPop = (mq.size() != 0) && out_ready;
            if (mAcc) begin
                mHi  = int'(in_struct[5:2]);
                mLo  = int'(in_struct[1:0]);
                mTop = int'(in_matrix[1][3:2]);
                mLoS = (mLo >= 2) ? mLo - 4 : mLo;
                mBad = (int'(in_matrix[0]) != mHi)
                    || (int'(in_matrix[1][1:0]) != mLo)
                    || (int'(in_unpacked0[2:0]) != (mHi % 8))
                    || (int'(in_unpacked1[1:0]) != mLo)
                    || (int'(in_unpacked1[2]) != (mHi % 2));
                mEntry = {8'(mTop * 64 + mLo * 16 + mHi), 8'(mLoS), mBad};
                if (mBad) begin
                    if (mErr8 < 255) mErr8++;
                    if (mErr2 < 3) mErr2++;
                    mSticky = 1;
                end
            end
            if (mPop) void'(mq.pop_front());
            if (mAcc) mq.push_back(mEntry);
        end
        modelReady = 1;
    end

    always @(negedge clk) begin
        if (modelReady) begin
            automatic logic [16:0] h = (mq.size() != 0) ? mq[0] : 17'h0;
            checkOutput("in_ready",      in_ready,      32'(mq.size() < DEPTH));
            checkOutput("out_valid",     out_valid,     32'(mq.size() != 0));
            checkOutput("count",         count,         32'(mq.size()));
            checkOutput("out_bus",       out_bus,       32'(h[16:9]));
            checkOutput("out_lo_sext",   out_lo_sext,   32'(h[8:1]));
            checkOutput("out_err",       out_err,       32'(h[0]));
            checkOutput("err_count",     err_count,     32'(mErr8));
            checkOutput("err_sticky",    err_sticky,    32'(mSticky));
            checkOutput("sat_count",     s_count,       32'(mq.size()));
            checkOutput("sat_out_bus",   s_out_bus,     32'(h[16:9]));
            checkOutput("sat_err_count", s_err_count,   32'(mErr2));
            checkOutput("sat_sticky",    s_err_sticky,  32'(mSticky));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [5:0] s, input logic [7:0] m,
                                 input logic [2:0] a, input logic [2:0] b);
        in_valid     = v;
        in_struct    = s;
        in_matrix    = m;
        in_unpacked0 = a;
        in_unpacked1 = b;
    endtask

    // Builds the redundant copies of a source bus, optionally corrupting one copy bit.
    task automatic applyRecord(input logic [7:0] bus, input bit bad);
        logic [11:0] red;
        int k;
        red = {bus[3:0], bus[5:4], bus[2:0], bus[0], bus[5:4]};
        if (bad) begin
            k = $urandom_range(0, 11);
            red[k] = ~red[k];
        end
        applyStimulus(1'b1, {bus[3:0], bus[5:4]}, {bus[7:6], red[7:6], red[11:8]},
                      red[5:3], red[2:0]);
    endtask

    task automatic pushRecord(input logic [7:0] bus, input bit bad);
        int n = 0;
        applyRecord(bus, bad);
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_wait: in_ready stayed 0 expected 1");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (count != 0 && n < 50) begin
            step();
            n++;
        end
        checkOutput("drain_count", count, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 6'h0, 8'h0, 3'h0, 3'h0);
        step();
        step();
        rst = 1'b0;
        checkOutput("reset_in_ready", in_ready, 32'd1);
        checkOutput("reset_count", count, 32'd0);
        checkOutput("reset_out_bus", out_bus, 32'd0);

        // Clean record, one cycle of latency
        applyStimulus(1'b1, {4'hA, 2'b01}, {4'hD, 4'hA}, 3'b010, 3'b001);
        step();
        in_valid = 1'b0;
        checkOutput("clean_valid", out_valid, 32'd1);
        checkOutput("clean_bus", out_bus, 32'hDA);
        checkOutput("clean_sext", out_lo_sext, 32'h01);
        checkOutput("clean_err", out_err, 32'd0);
        checkOutput("clean_errcnt", err_count, 32'd0);
        step();

        // Negative low part
        applyStimulus(1'b1, {4'h3, 2'b10}, {4'hE, 4'h3}, 3'b011, 3'b110);
        step();
        in_valid = 1'b0;
        checkOutput("signed_bus", out_bus, 32'hE3);
        checkOutput("signed_sext", out_lo_sext, 32'hFE);
        checkOutput("signed_err", out_err, 32'd0);
        step();

        // Mismatch followed by a clean record
        applyStimulus(1'b1, {4'hA, 2'b01}, {4'hD, 4'hB}, 3'b010, 3'b001);
        step();
        applyStimulus(1'b1, {4'hA, 2'b01}, {4'hD, 4'hA}, 3'b010, 3'b001);
        checkOutput("mism_err", out_err, 32'd1);
        checkOutput("mism_errcnt", err_count, 32'd1);
        checkOutput("mism_sticky", err_sticky, 32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("after_err", out_err, 32'd0);
        checkOutput("after_errcnt", err_count, 32'd1);
        checkOutput("after_sticky", err_sticky, 32'd1);
        step();

        // Back-pressure: fifth record must wait for the first pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) pushRecord(8'($urandom), 1'b0);
        applyRecord(8'h5C, 1'b0);
        step();
        step();
        checkOutput("full_count", count, 32'd4);
        checkOutput("full_in_ready", in_ready, 32'd0);
        out_ready = 1'b1;
        step();
        checkOutput("first_pop_count", count, 32'd3);
        checkOutput("first_pop_ready", in_ready, 32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("refill_count", count, 32'd3);
        drain();

        // Steady state at occupancy 2 with pointer wrap
        out_ready = 1'b0;
        pushRecord(8'($urandom), 1'b0);
        pushRecord(8'($urandom), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyRecord(8'($urandom), 1'b0);
            step();
            checkOutput("steady_count", count, 32'd2);
        end
        drain();

        // Saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            applyRecord(8'($urandom), 1'b1);
            step();
        end
        in_valid = 1'b0;
        checkOutput("sat_errcnt_lit", s_err_count, 32'd3);
        checkOutput("wide_errcnt_lit", err_count, 32'd6);
        drain();

        // Reset with entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pushRecord(8'($urandom), 1'b0);
        checkOutput("pre_reset_count", count, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst_count", count, 32'd0);
        checkOutput("rst_valid", out_valid, 32'd0);
        checkOutput("rst_errcnt", err_count, 32'd0);
        checkOutput("rst_sat_errcnt", s_err_count, 32'd0);
        checkOutput("rst_sticky", err_sticky, 32'd0);
        checkOutput("rst_in_ready", in_ready, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyRecord(8'($urandom), $urandom_range(0, 3) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        drain();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memo_decoder.md
# memo_decoder

Receive-side counterpart of the memo child's packing logic. It accepts one memo record per handshake: a `memo_struct_t` word, a `[1:0][3:0]` packed matrix and two 3-bit unpacked lanes. It reconstructs the original 8-bit bus, cross-checks the redundant encodings against each other, and buffers the results in a small FIFO toward a valid/ready consumer. It sits downstream of any block that registers `memo_struct_t`, packed-matrix and unpacked-bus copies of one source bus, and it doubles as an elaboration fixture for struct, packed-array and unpacked-array reads.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of two and at least 2.
- `ERR_CNT_W`, 8: width of the saturating error counter.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input record present.
- `in_ready`  out  1  decoder can accept a record.
- `in_struct`  in  6  `memo_struct_t` = {`parts_hi[3:0]`, `parts_lo[1:0]` signed}.
- `in_matrix`  in  8  `logic [1:0][3:0]`; `[0]` is the low nibble copy, `[1]` is the high nibble copy.
- `in_unpacked0`  in  3  signed; copy of bus[2:0].
- `in_unpacked1`  in  3  signed; {bus[0], bus[5:4]}.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head.
- `out_bus`  out  8  reconstructed bus.
- `out_lo_sext`  out  8  `parts_lo` sign-extended to 8 bits.
- `out_err`  out  1  head record failed its consistency check.
- `err_count`  out  `ERR_CNT_W`  count of accepted records with error; saturating.
- `err_sticky`  out  1  set by any accepted error record.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Accept:** a record is accepted when `in_valid && in_ready`. `in_ready = (count < DEPTH)` and is a function of state only, never of `out_ready`. When full, no record is accepted even if a pop happens in the same cycle.
- **Reconstruction**, with hi = `in_struct[5:2]` and lo = `in_struct[1:0]`:
  - `bus = {in_matrix[1][3:2], lo, hi}`.
  - `lo_sext = {{6{lo[1]}}, lo}`.
- **Error term:** `err` is the OR of these mismatches:
  - `in_matrix[0] != hi`
  - `in_matrix[1][1:0] != lo`
  - `in_unpacked0 != hi[2:0]`
  - `in_unpacked1[1:0] != lo`
  - `in_unpacked1[2] != hi[0]`
- **FIFO write:** an accepted record writes {bus, lo_sext, err} at the write pointer. Pointers wrap modulo `DEPTH`.
- **Pop:** occurs when `out_valid && out_ready`. A pop while empty is ignored.
- **Push and pop in one cycle** (non-empty, non-full): `count` is unchanged, data order is preserved.
- **Error accounting** happens on accept, not on pop:
  - If `err`, `err_count` increments, saturating at all-ones.
  - `err_sticky` goes to 1 and stays there; only `rst` clears it.
- **Outputs:**
  - `out_valid = (count != 0)`.
  - When `count == 0`, `out_bus`, `out_lo_sext` and `out_err` read 0.
  - Otherwise they show the head entry.
  - Outputs hold stable while `out_valid && !out_ready`.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `count`=0, `out_bus`=0, `out_lo_sext`=0, `out_err`=0, `err_count`=0, `err_sticky`=0.
- **Reset mid-operation:** all buffered entries are discarded at that edge, and the reset values are visible in the next cycle.
- **Latency:** a record accepted at edge N appears on `out_*` with `out_valid`=1 in the cycle after edge N. There is no combinational input-to-output path.
- **Update edge:** `err_count`/`err_sticky` update at the same edge as the accept.
- **Full:** `in_ready` drops in the cycle after the `DEPTH`th unpopped accept. It rises in the cycle after the first pop.
- **Throughput:** one record per cycle when the consumer keeps `out_ready`=1.

## Test plan
- **Clean record, one cycle of latency:** struct {4'hA, 2'b01}, matrix {4'hD, 4'hA}, unpacked0=3'b010, unpacked1=3'b001 -> next cycle `out_valid`=1, `out_bus`=8'hDA, `out_lo_sext`=8'h01, `out_err`=0, `err_count`=0.
- **Signed lane:** lo=2'b10, hi=4'h3, matrix {4'hE, 4'h3}, unpacked0=3'b011, unpacked1=3'b110 -> `out_bus`=8'hE3, `out_lo_sext`=8'hFE, `out_err`=0.
- **Mismatch:** the clean record with matrix[0]=4'hB -> `out_err`=1, `err_count`=1, `err_sticky`=1. A following clean record leaves `err_count` at 1 and `err_sticky` at 1.
- **Back-pressure:** `out_ready`=0, present 5 records with `DEPTH`=4 -> `count`=4, `in_ready`=0, 5th record held. Then `out_ready`=1 -> records drain in order, the 5th is accepted the cycle after the first pop, and `count` returns to 0.
- **Steady state and wrap:** at `count`=2, push and pop together for 10 cycles -> `count` stays 2, outputs match input order, pointers wrap with no loss.
- **Saturation and reset:** `ERR_CNT_W`=2, 5 error records -> `err_count`=3. Then assert `rst` with 3 entries buffered -> next cycle `count`=0, `out_valid`=0, `err_count`=0, `err_sticky`=0, `in_ready`=1.
